// File: rtl/sqrt_result_reorder.sv
// In-order result collector for the sqrt formula distributor: grants tags, buffers
// out-of-order worker results and releases them in allocation order on valid/ready.
module sqrt_result_reorder #(
  parameter int N_TAGS = 8,
  parameter int W = 32,
  localparam int TW = $clog2(N_TAGS),
  localparam int CW = $clog2(N_TAGS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req,
  output logic          alloc_rdy,
  output logic [TW-1:0] alloc_tag,
  input  logic          cmp_vld,
  input  logic [TW-1:0] cmp_tag,
  input  logic [W-1:0]  cmp_data,
  output logic          res_vld,
  output logic [W-1:0]  res,
  input  logic          res_rdy,
  output logic [CW-1:0] count,
  output logic          err
);

  logic [TW-1:0]     wr_ptr;
  logic [TW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_nxt;
  logic [N_TAGS-1:0] alloc_q;
  logic [N_TAGS-1:0] done_q;
  logic [W-1:0]      data_q [N_TAGS];
  logic              err_q;

  logic alloc_fire;
  logic retire_fire;
  logic cmp_ok;

  assign alloc_rdy   = (count_q != CW'(N_TAGS));
  assign alloc_tag   = wr_ptr;
  assign alloc_fire  = alloc_req && alloc_rdy;
  assign res_vld     = alloc_q[rd_ptr] && done_q[rd_ptr];
  assign res         = data_q[rd_ptr];
  assign retire_fire = res_vld && res_rdy;
  // A slot being allocated this cycle still reads alloc=0, and a slot being
  // retired reads done=1, so both same-cycle collisions fall out as errors here.
  assign cmp_ok      = cmp_vld && alloc_q[cmp_tag] && !done_q[cmp_tag];
  assign count       = count_q;
  assign err         = err_q;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_nxt = count_q;
    if (alloc_fire && !retire_fire) begin
      count_nxt = count_q + CW'(1);
    end else if (!alloc_fire && retire_fire) begin
      count_nxt = count_q - CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      if (alloc_fire) begin
        alloc_q[wr_ptr] <= 1'b1;
        done_q[wr_ptr]  <= 1'b0;
        wr_ptr          <= wr_ptr + TW'(1);
      end
      if (cmp_ok) begin
        done_q[cmp_tag] <= 1'b1;
      end else if (cmp_vld) begin
        err_q <= 1'b1;
      end
      if (retire_fire) begin
        alloc_q[rd_ptr] <= 1'b0;
        done_q[rd_ptr]  <= 1'b0;
        rd_ptr          <= rd_ptr + TW'(1);
      end
    end
  end

  // NOTE: the data array has no reset; validity is carried entirely by alloc/done bits.
  always_ff @(posedge clk) begin
    if (cmp_ok) begin
      data_q[cmp_tag] <= cmp_data;
    end
  end

endmodule
